// File: rtl/eth_pkg.sv
// Shared constants for the UDP digit path: ASCII encoding offsets and transmit FSM states.
package eth_pkg;

   localparam logic [7:0] AsciiDigit = 8'h30;
   localparam logic [7:0] AsciiAlpha = 8'h37;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StSend = 2'd2
   } tx_state_e;

   // Map a 4-bit value onto its upper-case ASCII hex character.
   function automatic logic [7:0] encode_digit(input logic [3:0] d);
      return (d < 4'd10) ? (AsciiDigit + {4'h0, d}) : (AsciiAlpha + {4'h0, d});
   endfunction

endpackage

// File: rtl/udp_digit_tx_if.sv
// Digit input handshake plus the request/length/data exchange with the UDP transmit engine.
interface udp_digit_tx_if;

   logic [3:0]  num;
   logic        num_vld;
   logic        num_rdy;
   logic        udp_tx_req;
   logic [15:0] udp_tx_len;
   logic        udp_tx_ack;
   logic        udp_tx_data_req;
   logic [7:0]  udp_tx_data;
   logic        udp_tx_data_vld;
   logic [15:0] pkt_cnt;

   modport master (
      input  num, num_vld, udp_tx_ack, udp_tx_data_req,
      output num_rdy, udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_data_vld, pkt_cnt
   );

   modport slave (
      output num, num_vld, udp_tx_ack, udp_tx_data_req,
      input  num_rdy, udp_tx_req, udp_tx_len, udp_tx_data, udp_tx_data_vld, pkt_cnt
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; read data is the current head (show-ahead).
module sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 128
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       push,
   input  logic [Width-1:0]           wdata,
   input  logic                       pop,
   output logic [Width-1:0]           rdata,
   output logic                       full,
   output logic [$clog2(Depth):0]     count
);

   localparam int unsigned AddrW = $clog2(Depth);

   logic [Width-1:0] mem [Depth];
   logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AddrW:0]   count_q;
   logic             push_ok, pop_ok;

   assign full    = (count_q == (AddrW + 1)'(Depth));
   assign push_ok = push && !full;
   assign pop_ok  = pop && (count_q != '0);
   assign rdata   = mem[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/udp_digit_tx.sv
// Encodes digits to ASCII hex, buffers them and releases them to the UDP engine as packets
// when a full batch is ready or a partial batch has gone idle.
module udp_digit_tx
   import eth_pkg::*;
#(
   parameter int unsigned MAX_LEN     = 64,
   parameter int unsigned DEPTH       = 128,
   parameter int unsigned TIMEOUT_CYC = 125000
) (
   input logic            rgmii_clk,
   input logic            rstn,
   udp_digit_tx_if.master bus
);

   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned TmrW = $clog2(TIMEOUT_CYC + 1);

   tx_state_e       state_q, state_d;
   logic [TmrW-1:0] timer_q, timer_d;
   logic [15:0]     len_q, len_d;
   logic [15:0]     byte_cnt_q, byte_cnt_d;
   logic [15:0]     pkt_cnt_q, pkt_cnt_d;
   logic [7:0]      data_q;
   logic            vld_q;
   logic            run_q;

   logic            full;
   logic [CntW-1:0] fifo_count;
   logic [7:0]      fifo_rdata, wr_char;
   logic [15:0]     avail;
   logic            push, pop, last, flush;

   // Holds num_rdy low through reset and releases it on the first clock afterwards.
   assign bus.num_rdy = run_q && !full;

   assign push    = bus.num_vld && bus.num_rdy;
   assign wr_char = encode_digit(bus.num);
   assign pop     = (state_q == StSend) && bus.udp_tx_data_req && (byte_cnt_q < len_q);
   assign last    = pop && ((byte_cnt_q + 16'd1) == len_q);
   assign avail   = 16'(fifo_count);
   assign flush   = (avail >= 16'(MAX_LEN)) ||
                    ((avail != 16'd0) && (timer_q == TmrW'(TIMEOUT_CYC - 1)));

   sync_fifo #(
      .Width(8),
      .Depth(DEPTH)
   ) u_fifo (
      .clk  (rgmii_clk),
      .rstn (rstn),
      .push (push),
      .wdata(wr_char),
      .pop  (pop),
      .rdata(fifo_rdata),
      .full (full),
      .count(fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = '0;
      len_d      = len_q;
      byte_cnt_d = byte_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (!push && (avail != 16'd0)) timer_d = timer_q + 1'b1;
            if (flush) begin
               state_d = StReq;
               len_d   = (avail > 16'(MAX_LEN)) ? 16'(MAX_LEN) : avail;
            end
         end
         StReq: begin
            if (bus.udp_tx_ack) begin
               state_d    = StSend;
               byte_cnt_d = '0;
            end
         end
         StSend: begin
            if (pop) byte_cnt_d = byte_cnt_q + 16'd1;
            if (last) begin
               state_d   = StIdle;
               pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge rgmii_clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         len_q      <= '0;
         byte_cnt_q <= '0;
         pkt_cnt_q  <= '0;
         data_q     <= '0;
         vld_q      <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         len_q      <= len_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         vld_q      <= pop;
         run_q      <= 1'b1;
         if (pop) data_q <= fifo_rdata;
      end
   end

   assign bus.udp_tx_req      = (state_q == StReq);
   assign bus.udp_tx_len      = len_q;
   assign bus.udp_tx_data     = data_q;
   assign bus.udp_tx_data_vld = vld_q;
   assign bus.pkt_cnt         = pkt_cnt_q;

endmodule

// File: tb/tb_udp_digit_tx.sv
// Directed/random bench for udp_digit_tx with a byte-queue scoreboard of the expected payload.
module tb_udp_digit_tx;
   import eth_pkg::*;

   localparam int MaxLen = 64;
   localparam int Depth  = 128;
   localparam int Tmo    = 200;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #4 clk = ~clk;

   udp_digit_tx_if bus ();

   udp_digit_tx #(
      .MAX_LEN    (MaxLen),
      .DEPTH      (Depth),
      .TIMEOUT_CYC(Tmo)
   ) dut (
      .rgmii_clk(clk),
      .rstn     (rstn),
      .bus      (bus)
   );

   int         tests = 0;
   int         fails = 0;
   logic [7:0] model_q[$];
   logic [3:0] pend[$];
   int         exp_pkt = 0;
   int         since_push = 0;
   int         vld_seen = 0;

   function automatic logic [7:0] ref_char(input int d);
      if (d < 10) return 8'(48 + d);
      return 8'(65 + d - 10);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, feed pending digits, then score outputs 1 ns after the edge.
   task automatic tick(input bit ack, input bit dreq);
      bit acc;
      int cnt_b;
      bus.udp_tx_ack      = ack;
      bus.udp_tx_data_req = dreq;
      if (pend.size() > 0) begin
         bus.num_vld = 1'b1;
         bus.num     = pend[0];
      end else begin
         bus.num_vld = 1'b0;
         bus.num     = 4'h0;
      end
      acc   = bus.num_vld && bus.num_rdy;
      cnt_b = int'(dut.fifo_count);
      @(posedge clk);
      #1;
      if (bus.udp_tx_data_vld) begin
         vld_seen++;
         check("payload_avail", 32'(model_q.size() > 0), 32'd1);
         if (model_q.size() > 0) check("payload", 32'(bus.udp_tx_data), 32'(model_q.pop_front()));
         if (acc) check("count_pushpop", 32'(dut.fifo_count), 32'(cnt_b));
      end
      if (acc) begin
         model_q.push_back(ref_char(int'(pend.pop_front())));
         since_push = 0;
      end else begin
         since_push++;
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.udp_tx_req && n < 2000) begin
         tick(1'b0, 1'b0);
         n++;
      end
      check("req_seen", 32'(bus.udp_tx_req), 32'd1);
   endtask

   task automatic serve(input int exp_len, input int ack_dly, input int extra, input int push_n);
      wait_req();
      check("tx_len", 32'(bus.udp_tx_len), 32'(exp_len));
      repeat (ack_dly) tick(1'b0, 1'b0);
      check("req_held", 32'(bus.udp_tx_req), 32'd1);
      tick(1'b1, 1'b0);
      check("req_fall", 32'(bus.udp_tx_req), 32'd0);
      repeat (push_n) pend.push_back(4'($urandom_range(0, 15)));
      vld_seen = 0;
      for (int i = 0; i < exp_len + extra; i++) begin
         tick(1'b0, 1'b1);
         if (i == exp_len - 1) begin
            exp_pkt++;
            check("pkt_cnt_last", 32'(bus.pkt_cnt), 32'(exp_pkt));
            check("idle_after_last", 32'(dut.state_q), 32'(StIdle));
         end
      end
      check("vld_count", 32'(vld_seen), 32'(exp_len));
      check("pkt_cnt_once", 32'(bus.pkt_cnt), 32'(exp_pkt));
      check("fifo_level", 32'(dut.fifo_count), 32'(model_q.size()));
   endtask

   task automatic do_reset();
      bus.num = 4'h0; bus.num_vld = 1'b0; bus.udp_tx_ack = 1'b0; bus.udp_tx_data_req = 1'b0;
      rstn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_num_rdy", 32'(bus.num_rdy), 32'd0);
      check("rst_req", 32'(bus.udp_tx_req), 32'd0);
      check("rst_len", 32'(bus.udp_tx_len), 32'd0);
      check("rst_data", 32'(bus.udp_tx_data), 32'd0);
      check("rst_vld", 32'(bus.udp_tx_data_vld), 32'd0);
      check("rst_pkt_cnt", 32'(bus.pkt_cnt), 32'd0);
      rstn = 1'b1;
      model_q.delete();
      pend.delete();
      exp_pkt = 0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("num_rdy_after_rst", 32'(bus.num_rdy), 32'd1);
   endtask

   initial begin
      do_reset();

      // Full packet of cycling decimal digits.
      for (int i = 0; i < 64; i++) pend.push_back(4'(i % 10));
      serve(64, 3, 0, 0);

      // Short batch flushed by the idle timeout, then extra requests past the end.
      pend.push_back(4'd1); pend.push_back(4'd2); pend.push_back(4'd10);
      pend.push_back(4'd15); pend.push_back(4'd0);
      wait_req();
      check("timeout_cycles", 32'(since_push), 32'(Tmo));
      serve(5, 2, 3, 0);

      // Pushes overlapping the drain land in the following packet.
      for (int i = 0; i < 64; i++) pend.push_back(4'($urandom_range(0, 15)));
      serve(64, 1, 0, 10);
      serve(10, 0, 0, 0);

      // Fill beyond capacity with the engine stalled, then drain.
      do_reset();
      for (int i = 0; i < 130; i++) pend.push_back(4'($urandom_range(0, 15)));
      for (int n = 0; n < 300 && pend.size() > 2; n++) tick(1'b0, 1'b0);
      repeat (3) tick(1'b0, 1'b0);
      check("accepted", 32'(130 - pend.size()), 32'd128);
      check("num_rdy_full", 32'(bus.num_rdy), 32'd0);
      check("fifo_full_level", 32'(dut.fifo_count), 32'(Depth));
      serve(64, 3, 0, 0);
      serve(64, 3, 0, 0);
      serve(2, 3, 0, 0);
      check("pkt_total", 32'(bus.pkt_cnt), 32'd3);

      // Reset in the middle of a packet.
      for (int i = 0; i < 20; i++) pend.push_back(4'($urandom_range(0, 15)));
      wait_req();
      tick(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      check("vld_before_rst", 32'(bus.udp_tx_data_vld), 32'd1);
      rstn = 1'b0;
      #1;
      check("rst_mid_req", 32'(bus.udp_tx_req), 32'd0);
      check("rst_mid_vld", 32'(bus.udp_tx_data_vld), 32'd0);
      check("rst_mid_pkt", 32'(bus.pkt_cnt), 32'd0);
      #2;
      rstn = 1'b1;
      model_q.delete();
      pend.delete();
      exp_pkt = 0;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check("post_rst_count", 32'(dut.fifo_count), 32'd0);
      check("post_rst_state", 32'(dut.state_q), 32'(StIdle));
      check("post_rst_pkt", 32'(bus.pkt_cnt), 32'd0);
      check("post_rst_rdy", 32'(bus.num_rdy), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
